// File: rtl/imem_loader.sv
// imem_loader: instruction RAM with a combinational CPU fetch port and a
// host byte-stream program loader. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          DEPTH       = 256,
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] FILL_WORD   = 16'h0000,
  parameter int          START_DELAY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       i_datain,
  input  logic              load_req,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [7:0]        host_byte,
  input  logic              host_last,
  output logic              cpu_reset,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic [ADDR_W:0]   loaded_words,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(START_DELAY - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, LOAD_HI, LOAD_LO, SETTLE, START, RUN, CHK_HI, CHK_LO, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, SETTLE, START, RUN
  } state_t;
`endif

  state_t state, state_nxt;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        hi_q;
  logic [CNT_W-1:0]  cnt;

  logic        xfer;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        latch_hi;
  logic        start_load;
  logic        release_cpu;
  logic        fire;
  logic        end_load;
  logic        reads_open;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [7:0]  chk_hi_q;
  logic        latch_chk;
  logic        chk_bad;
  logic        err_q;
`endif

  assign xfer = host_valid && host_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    wr_en      = 1'b0;
    wr_data    = {hi_q, host_byte};
    latch_hi   = 1'b0;
    start_load = 1'b0;
    fire       = 1'b0;
    end_load   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    latch_chk  = 1'b0;
    chk_bad    = 1'b0;
`endif
    unique case (state)
      IDLE, RUN: begin
        if (load_req) begin
          start_load = 1'b1;
          state_nxt  = LOAD_HI;
        end
      end
      LOAD_HI: begin
        host_ready = 1'b1;
        if (xfer) begin
          latch_hi = 1'b1;
          if (host_last) begin
            wr_en    = 1'b1;
            wr_data  = {host_byte, 8'h00};
            end_load = 1'b1;
          end else begin
            state_nxt = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        host_ready = 1'b1;
        if (xfer) begin
          wr_en = 1'b1;
          if (host_last || wr_ptr == LAST_PTR) begin
            end_load = 1'b1;
          end else begin
            state_nxt = LOAD_HI;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = START;
        end
      end
      START: begin
        fire      = 1'b1;
        state_nxt = RUN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK_HI: begin
        host_ready = 1'b1;
        if (xfer) begin
          latch_chk = 1'b1;
          state_nxt = CHK_LO;
        end
      end
      CHK_LO: begin
        host_ready = 1'b1;
        if (xfer) begin
          if ({chk_hi_q, host_byte} == sum_q) begin
            state_nxt = SETTLE;
          end else begin
            chk_bad   = 1'b1;
            state_nxt = ERROR;
          end
        end
      end
      ERROR: begin
        if (load_req) begin
          start_load = 1'b1;
          state_nxt  = LOAD_HI;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (end_load) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      state_nxt = CHK_HI;
`else
      state_nxt = SETTLE;
`endif
    end
  end

  // The CPU leaves reset only once the image is accepted (checksum included).
  assign release_cpu = (state_nxt == SETTLE) && (state != SETTLE);

  // Loader datapath and CPU control outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      loaded_words <= '0;
      hi_q         <= '0;
      cnt          <= '0;
      cpu_reset    <= 1'b1;
      cpu_enable   <= 1'b0;
      cpu_start    <= 1'b0;
    end else begin
      cpu_start <= fire;
      if (start_load) begin
        wr_ptr       <= '0;
        loaded_words <= '0;
        cpu_reset    <= 1'b1;
        cpu_enable   <= 1'b0;
      end
      if (latch_hi) begin
        hi_q <= host_byte;
      end
      if (wr_en) begin
        wr_ptr       <= wr_ptr + 1'b1;
        loaded_words <= loaded_words + 1'b1;
      end
      if (release_cpu) begin
        cpu_reset <= 1'b0;
        cnt       <= CNT_INIT;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fire) begin
        cpu_enable <= 1'b1;
      end
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running word sum and checksum capture; err is sticky until a new load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q    <= '0;
      chk_hi_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_load) begin
        sum_q <= '0;
        err_q <= 1'b0;
      end else if (wr_en) begin
        sum_q <= sum_q + wr_data;
      end
      if (latch_chk) begin
        chk_hi_q <= host_byte;
      end
      if (chk_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Busy flag and read gating while an image is in flight.
  always_comb begin
    busy       = 1'b0;
    reads_open = 1'b1;
    unique case (state)
      LOAD_HI, LOAD_LO: begin
        busy       = 1'b1;
        reads_open = 1'b0;
      end
      SETTLE: begin
        busy = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK_HI, CHK_LO: begin
        busy       = 1'b1;
        reads_open = 1'b0;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Zero-latency fetch; unloaded addresses return the fill word.
  always_comb begin
    i_datain = FILL_WORD;
    if (reads_open && ({1'b0, i_addr} < loaded_words)) begin
      i_datain = mem[i_addr];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors plus scoreboarded program loads for
// imem_loader (checksum path exercised when IMEM_LOADER_CHECKSUM_EN is set).
module tb_imem_loader;

  localparam logic [15:0] FILL = 16'h0000;

  logic        clock;
  logic        reset;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic        load_req;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_byte;
  logic        host_last;
  logic        cpu_reset;
  logic        cpu_enable;
  logic        cpu_start;
  logic [8:0]  loaded_words;
  logic        busy;
  logic        err;

  imem_loader #(
    .DEPTH(256), .ADDR_W(8), .FILL_WORD(FILL), .START_DELAY(2)
  ) dut (
    .clock(clock), .reset(reset), .i_addr(i_addr), .i_datain(i_datain),
    .load_req(load_req), .host_valid(host_valid), .host_ready(host_ready),
    .host_byte(host_byte), .host_last(host_last), .cpu_reset(cpu_reset),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .loaded_words(loaded_words), .busy(busy), .err(err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } rd_vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  int tx_last;
  rd_vec_t exp_q[$];
  rd_vec_t vt[6];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int n);
    for (int k = 0; k < (n + 1) / 2; k++) begin
      rd_vec_t e;
      logic [7:0] lo;
      lo = (2 * k + 1 < n) ? tx_q[2 * k + 1] : 8'h00;
      e.addr = 8'(k);
      e.data = {tx_q[2 * k], lo};
      exp_q.push_back(e);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic add_chk(input int n, input logic [15:0] delta);
    logic [15:0] s;
    logic [7:0] lo;
    s = 16'h0;
    for (int k = 0; k < (n + 1) / 2; k++) begin
      lo = (2 * k + 1 < n) ? tx_q[2 * k + 1] : 8'h00;
      s = s + {tx_q[2 * k], lo};
    end
    s = s + delta;
    tx_q.push_back(s[15:8]);
    tx_q.push_back(s[7:0]);
  endtask
`endif

  task automatic pulse_load;
    @(negedge clock);
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
  endtask

  task automatic send(input bit rnd);
    int idx;
    int guard;
    bit acc;
    idx = 0;
    guard = 0;
    while (idx < tx_q.size() && guard < 5000) begin
      @(negedge clock);
      host_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      host_byte  = tx_q[idx];
      host_last  = (idx == tx_last);
      acc = host_valid && host_ready;
      @(posedge clock);
      if (acc) idx++;
      guard++;
    end
    #1;
    host_valid = 1'b0;
    host_last  = 1'b0;
    check("send_count", idx, tx_q.size());
  endtask

  task automatic wait_start;
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cpu_start && n < 20);
    check("start_seen", cpu_start, 1);
    check("enable_at_start", cpu_enable, 1);
  endtask

  task automatic drain;
    rd_vec_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i_addr = e.addr;
      #1;
      check($sformatf("rd%0d", e.addr), i_datain, e.data);
    end
  endtask

  initial begin
    vt[0] = '{8'd0,   16'h1234};
    vt[1] = '{8'd1,   16'h5678};
    vt[2] = '{8'd2,   FILL};
    vt[3] = '{8'd3,   FILL};
    vt[4] = '{8'd128, FILL};
    vt[5] = '{8'd255, FILL};

    reset = 1'b0;
    i_addr = 8'd0;
    load_req = 1'b0;
    host_valid = 1'b0;
    host_byte = 8'h00;
    host_last = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_cpu_enable", cpu_enable, 0);
    check("rst_cpu_start", cpu_start, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_loaded", loaded_words, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_read", i_datain, FILL);
    reset = 1'b1;

    // Four-byte program and release timing.
    tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    tx_last = 3;
    push_exp(4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(4, 16'h0);
`endif
    pulse_load;
    @(negedge clock);
    check("t1_reset_held", cpu_reset, 1);
    check("t1_busy", busy, 1);
    check("t1_ready", host_ready, 1);
    send(0);
    @(negedge clock);
    check("t1_reset_fall", cpu_reset, 0);
    check("t1_start_e0", cpu_start, 0);
    @(negedge clock);
    check("t1_start_e1", cpu_start, 0);
    @(negedge clock);
    check("t1_start_e2", cpu_start, 0);
    check("t1_en_e2", cpu_enable, 0);
    @(negedge clock);
    check("t1_start_e3", cpu_start, 1);
    check("t1_en_e3", cpu_enable, 1);
    @(negedge clock);
    check("t1_start_e4", cpu_start, 0);
    check("t1_en_e4", cpu_enable, 1);
    check("t1_loaded", loaded_words, 2);
    drain;
    for (int i = 0; i < 6; i++) begin
      i_addr = vt[i].addr;
      #1;
      check($sformatf("vec%0d", i), i_datain, vt[i].data);
    end

    // Odd length with a randomly stalling host.
    tx_q = '{8'hAB, 8'hCD, 8'hEF};
    tx_last = 2;
    push_exp(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(3, 16'h0);
`endif
    pulse_load;
    @(negedge clock);
    check("t3_reset_again", cpu_reset, 1);
    check("t3_enable_drop", cpu_enable, 0);
    send(1);
    wait_start;
    check("t3_loaded", loaded_words, 2);
    drain;

    // Fill the whole RAM without host_last.
    tx_q.delete();
    for (int i = 0; i < 512; i++) tx_q.push_back(8'((i * 7 + 3) ^ (i >> 8)));
    tx_last = -1;
    push_exp(512);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(512, 16'h0);
`endif
    pulse_load;
    send(0);
    @(negedge clock);
    check("t4_ready_off", host_ready, 0);
    check("t4_loaded", loaded_words, 256);
    check("t4_busy", busy, 1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      host_valid = 1'b1;
      host_byte = 8'hEE;
      check("t4_extra_ready", host_ready, 0);
    end
    host_valid = 1'b0;
`endif
    wait_start;
    check("t4_loaded_end", loaded_words, 256);
    drain;

    // Asynchronous reset mid-load, then a clean reload.
    tx_q = '{8'h11, 8'h22, 8'h33};
    tx_last = -1;
    pulse_load;
    send(0);
    i_addr = 8'd0;
    #1;
    check("t5_gated_read", i_datain, FILL);
    check("t5_partial", loaded_words, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_cpu", cpu_reset, 1);
    check("t5_rst_loaded", loaded_words, 0);
    check("t5_rst_read", i_datain, FILL);
    check("t5_rst_ready", host_ready, 0);
    @(negedge clock);
    reset = 1'b1;

    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_last = 3;
    push_exp(4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(4, 16'h0);
`endif
    pulse_load;
    send(0);
    @(negedge clock);
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
    @(negedge clock);
    check("t5_settle_ignore_busy", busy, 1);
    check("t5_settle_ignore_rst", cpu_reset, 0);
    check("t5_settle_ignore_rdy", host_ready, 0);
    wait_start;
    check("t5_loaded", loaded_words, 2);
    drain;

    @(negedge clock);
    load_req = 1'b1;
    host_valid = 1'b1;
    host_byte = 8'h77;
    check("t5_run_ready", host_ready, 0);
    @(posedge clock);
    #1;
    load_req = 1'b0;
    host_valid = 1'b0;
    @(negedge clock);
    check("t5_run_reset", cpu_reset, 1);
    check("t5_run_enable", cpu_enable, 0);
    check("t5_run_loaded", loaded_words, 0);
    check("t5_run_ready_on", host_ready, 1);
    tx_q = '{8'h99, 8'h88};
    tx_last = 1;
    push_exp(2);
    exp_q.push_back('{8'd1, FILL});
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_chk(2, 16'h0);
`endif
    send(0);
    wait_start;
    check("t5_reload_words", loaded_words, 1);
    drain;

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    tx_q = '{8'h00, 8'h01, 8'h00, 8'h02};
    tx_last = 3;
    push_exp(4);
    add_chk(4, 16'h0);
    check("t6_sum_lo", tx_q[5], 8'h03);
    pulse_load;
    send(0);
    wait_start;
    check("t6_err_ok", err, 0);
    drain;

    tx_q = '{8'h00, 8'h01, 8'h00, 8'h02};
    tx_last = 3;
    add_chk(4, 16'h1);
    pulse_load;
    send(0);
    @(negedge clock);
    check("t6_err_set", err, 1);
    check("t6_err_rst", cpu_reset, 1);
    check("t6_err_ready", host_ready, 0);
    begin
      int starts;
      starts = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        if (cpu_start) starts++;
      end
      check("t6_no_start", starts, 0);
    end
    check("t6_err_sticky", err, 1);
    pulse_load;
    @(negedge clock);
    check("t6_err_clear", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
